// File: rtl/blood_anim_ctrl.sv
// Blood-splatter animation controller for two fighters.
// Each fighter has a small IDLE/PLAY sequencer that steps through the
// shared blood frame ROM at a vsync-divided rate. Per scanned pixel the
// block decides which fighter (if any) owns the ROM, drives the ROM
// address, and one cycle later returns the masked blood colour.
module blood_anim_ctrl #(
  parameter int          NUM_FRAMES = 29,
  parameter int          FRAME_DIV  = 4,
  parameter logic [11:0] TRANSP     = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync_tick,
  input  logic        hit_p1,
  input  logic        hit_p2,
  input  logic [9:0]  p1_x,
  input  logic [9:0]  p1_y,
  input  logic [9:0]  p2_x,
  input  logic [9:0]  p2_y,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic [4:0]  rom_frame,
  output logic [5:0]  rom_row,
  output logic [5:0]  rom_col,
  input  logic [11:0] rom_data,
  output logic        blood_on,
  output logic [11:0] blood_rgb,
  output logic        busy_p1,
  output logic        busy_p2
);

  localparam int              DIV_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(FRAME_DIV - 1);
  localparam logic [4:0]      FRAME_LAST = 5'(NUM_FRAMES - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  // Index 0 is P1, index 1 is P2 throughout.
  state_t             state_q [2];
  state_t             state_d [2];
  logic [4:0]         frame_q [2];
  logic [4:0]         frame_d [2];
  logic [DIV_W-1:0]   div_q   [2];
  logic [DIV_W-1:0]   div_d   [2];
  logic [1:0]         hit_vec;
  logic [9:0]         org_x   [2];
  logic [9:0]         org_y   [2];
  logic [9:0]         off_x   [2];
  logic [9:0]         off_y   [2];
  logic [1:0]         in_win;
  logic               p1_own;
  logic               p2_own;
  logic               hit_d;
  logic               hit_q;

  assign hit_vec  = {hit_p2, hit_p1};
  assign org_x[0] = p1_x;
  assign org_y[0] = p1_y;
  assign org_x[1] = p2_x;
  assign org_y[1] = p2_y;

  // Sequencer state, frame and divider registers for both fighters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        frame_q[i] <= '0;
        div_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        frame_q[i] <= frame_d[i];
        div_q[i]   <= div_d[i];
      end
    end
  end

  // Next-state logic: a hit always (re)starts at frame 0 and swallows any
  // vsync tick in the same cycle; otherwise vsync advances the divider and
  // the divider rolls the frame, ending the animation after the last frame.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      frame_d[i] = frame_q[i];
      div_d[i]   = div_q[i];
      case (state_q[i])
        IDLE: begin
          if (hit_vec[i]) begin
            state_d[i] = PLAY;
            frame_d[i] = '0;
            div_d[i]   = '0;
          end
        end
        PLAY: begin
          if (hit_vec[i]) begin
            frame_d[i] = '0;
            div_d[i]   = '0;
          end else if (vsync_tick) begin
            if (div_q[i] == DIV_LAST) begin
              div_d[i] = '0;
              if (frame_q[i] == FRAME_LAST) begin
                state_d[i] = IDLE;
                frame_d[i] = '0;
              end else begin
                frame_d[i] = frame_q[i] + 5'd1;
              end
            end else begin
              div_d[i] = div_q[i] + 1'b1;
            end
          end
        end
        default: begin
          state_d[i] = IDLE;
          frame_d[i] = '0;
          div_d[i]   = '0;
        end
      endcase
    end
  end

  // Window test in 11 bits so a sprite near the right/bottom edge is
  // clipped at 1023 instead of wrapping around to column/row 0.
  always_comb begin
    in_win = '0;
    for (int i = 0; i < 2; i++) begin
      off_x[i] = pixel_x - org_x[i];
      off_y[i] = pixel_y - org_y[i];
      in_win[i] = (state_q[i] == PLAY) &&
                  ({1'b0, pixel_x} >= {1'b0, org_x[i]}) &&
                  ({1'b0, pixel_x} <= ({1'b0, org_x[i]} + 11'd63)) &&
                  ({1'b0, pixel_y} >= {1'b0, org_y[i]}) &&
                  ({1'b0, pixel_y} <= ({1'b0, org_y[i]} + 11'd63));
    end
  end

  // ROM ownership and address: P1 has fixed priority, so on an overlap P2
  // is hidden even where P1's colour turns out to be transparent.
  always_comb begin
    p1_own    = in_win[0];
    p2_own    = !in_win[0] && in_win[1];
    hit_d     = p1_own || p2_own;
    rom_frame = '0;
    rom_row   = '0;
    rom_col   = '0;
    if (p1_own) begin
      rom_frame = frame_q[0];
      rom_row   = off_y[0][5:0];
      rom_col   = off_x[0][5:0];
    end else if (p2_own) begin
      rom_frame = frame_q[1];
      rom_row   = off_y[1][5:0];
      rom_col   = off_x[1][5:0];
    end
  end

  // Align the ownership flag with the ROM's one-cycle read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
    end
  end

  // Masked pixel back to the mixer, plus per-fighter busy flags.
  always_comb begin
    blood_on  = hit_q && (rom_data != TRANSP);
    blood_rgb = blood_on ? rom_data : 12'h000;
    busy_p1   = (state_q[0] == PLAY);
    busy_p2   = (state_q[1] == PLAY);
  end

endmodule

// File: tb/tb_blood_anim_ctrl.sv
// Self-checking bench for blood_anim_ctrl: a behavioural model tracks each
// fighter as "ticks elapsed since the hit", from which frame, window and
// ROM address follow by plain arithmetic. A per-cycle compare process plus
// a few literal expectations check the DUT.
module tb_blood_anim_ctrl;

  localparam int NUM_FRAMES = 29;
  localparam int FRAME_DIV  = 4;
  localparam int PLAY_TICKS = NUM_FRAMES * FRAME_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vsync_tick = 1'b0;
  logic        hit_p1 = 1'b0;
  logic        hit_p2 = 1'b0;
  logic [9:0]  p1_x = '0, p1_y = '0, p2_x = '0, p2_y = '0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic [4:0]  rom_frame;
  logic [5:0]  rom_row, rom_col;
  logic [11:0] rom_data = '0;
  logic        blood_on;
  logic [11:0] blood_rgb;
  logic        busy_p1, busy_p2;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  bit rom_override_en = 1'b0;
  logic [11:0] rom_override_val = '0;

  // Model state: active flag and vsync ticks elapsed since the last hit.
  int act [2];
  int t   [2];
  bit exp_on = 1'b0;
  logic [11:0] exp_rgb = '0;

  blood_anim_ctrl #(
    .NUM_FRAMES(NUM_FRAMES),
    .FRAME_DIV (FRAME_DIV),
    .TRANSP    (12'h000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .vsync_tick(vsync_tick),
    .hit_p1    (hit_p1),
    .hit_p2    (hit_p2),
    .p1_x      (p1_x),
    .p1_y      (p1_y),
    .p2_x      (p2_x),
    .p2_y      (p2_y),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .rom_frame (rom_frame),
    .rom_row   (rom_row),
    .rom_col   (rom_col),
    .rom_data  (rom_data),
    .blood_on  (blood_on),
    .blood_rgb (blood_rgb),
    .busy_p1   (busy_p1),
    .busy_p2   (busy_p2)
  );

  always #5 clk = ~clk;

  // Synthetic ROM contents: some addresses are transparent.
  function automatic logic [11:0] rom_fn(input int f, input int r, input int c);
    logic [11:0] v;
    if (((r ^ c) & 3) == 0) return 12'h000;
    v = {1'b1, 4'(f), 4'(r), 3'(c)};
    return v;
  endfunction

  // Registered-address ROM emulation driven by the DUT's address.
  always @(posedge clk) begin
    rom_data <= rom_override_en ? rom_override_val
                                : rom_fn(int'(rom_frame), int'(rom_row), int'(rom_col));
  end

  function automatic bit in_win(input int p);
    int ox, oy, px, py;
    ox = (p == 0) ? int'(p1_x) : int'(p2_x);
    oy = (p == 0) ? int'(p1_y) : int'(p2_y);
    px = int'(pixel_x);
    py = int'(pixel_y);
    return (act[p] != 0) && (px >= ox) && (px <= ox + 63) && (py >= oy) && (py <= oy + 63);
  endfunction

  function automatic void model_addr(output bit own, output int f, output int r, output int c);
    own = 1'b0; f = 0; r = 0; c = 0;
    if (in_win(0)) begin
      own = 1'b1; f = t[0] / FRAME_DIV;
      r = int'(pixel_y) - int'(p1_y); c = int'(pixel_x) - int'(p1_x);
    end else if (in_win(1)) begin
      own = 1'b1; f = t[1] / FRAME_DIV;
      r = int'(pixel_y) - int'(p2_y); c = int'(pixel_x) - int'(p2_x);
    end
  endfunction

  // Reference model: predict next-cycle pixel from pre-edge state, then
  // advance each fighter's tick count.
  always @(posedge clk or posedge reset) begin
    bit m_own;
    int mf, mr, mc;
    logic [11:0] nd;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin act[i] = 0; t[i] = 0; end
      exp_on = 1'b0; exp_rgb = '0;
    end else begin
      model_addr(m_own, mf, mr, mc);
      nd = rom_override_en ? rom_override_val : rom_fn(mf, mr, mc);
      exp_on  = m_own && (nd != 12'h000);
      exp_rgb = exp_on ? nd : 12'h000;
      for (int i = 0; i < 2; i++) begin
        if ((i == 0 && hit_p1) || (i == 1 && hit_p2)) begin
          act[i] = 1; t[i] = 0;
        end else if (act[i] != 0 && vsync_tick) begin
          t[i]++;
          if (t[i] == PLAY_TICKS) begin act[i] = 0; t[i] = 0; end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit c_own;
    int cf, cr, cc;
    if (chk_en) begin
      model_addr(c_own, cf, cr, cc);
      checkOutput("busy_p1",   int'(busy_p1),   act[0] != 0 ? 1 : 0);
      checkOutput("busy_p2",   int'(busy_p2),   act[1] != 0 ? 1 : 0);
      checkOutput("rom_frame", int'(rom_frame), cf);
      checkOutput("rom_row",   int'(rom_row),   cr);
      checkOutput("rom_col",   int'(rom_col),   cc);
      checkOutput("blood_on",  int'(blood_on),  int'(exp_on));
      checkOutput("blood_rgb", int'(blood_rgb), int'(exp_rgb));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse on the hit/vsync inputs.
  task automatic applyStimulus(input bit h1, input bit h2, input bit v);
    hit_p1 = h1; hit_p2 = h2; vsync_tick = v;
    step();
    hit_p1 = 1'b0; hit_p2 = 1'b0; vsync_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int fall_tick;
    int j, ox, oy;
    step(); step();
    reset = 1'b0;
    chk_en = 1'b1;
    #2;
    checkOutput("reset_busy_p1", int'(busy_p1), 0);
    checkOutput("reset_rom_frame", int'(rom_frame), 0);
    checkOutput("reset_blood_on", int'(blood_on), 0);

    // Full play with addressing/latency check at frame 5.
    p1_x = 10'd100; p1_y = 10'd50; pixel_x = 10'd110; pixel_y = 10'd60;
    p2_x = 10'd600; p2_y = 10'd600;
    applyStimulus(1'b1, 1'b0, 1'b0);
    #2;
    checkOutput("play_start_busy", int'(busy_p1), 1);
    checkOutput("play_start_frame", int'(rom_frame), 0);
    fall_tick = -1;
    for (int k = 1; k <= PLAY_TICKS; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      #2;
      if (busy_p1 == 1'b0 && fall_tick < 0) fall_tick = k;
      if (k == 20) begin
        checkOutput("addr_frame5", int'(rom_frame), 5);
        checkOutput("addr_row10", int'(rom_row), 10);
        checkOutput("addr_col10", int'(rom_col), 10);
        rom_override_en = 1'b1; rom_override_val = 12'hD00;
        step(); #2;
        checkOutput("lat_blood_on", int'(blood_on), 1);
        checkOutput("lat_blood_rgb", int'(blood_rgb), 12'hD00);
        rom_override_val = 12'h000;
        step(); #2;
        checkOutput("transp_blood_on", int'(blood_on), 0);
        checkOutput("transp_blood_rgb", int'(blood_rgb), 0);
        rom_override_en = 1'b0;
      end
      if (k == PLAY_TICKS - 1) begin
        checkOutput("last_frame", int'(rom_frame), NUM_FRAMES - 1);
        checkOutput("last_busy", int'(busy_p1), 1);
      end
    end
    checkOutput("busy_fall_tick", fall_tick, PLAY_TICKS);

    // Reset mid-animation at frame 10.
    applyStimulus(1'b1, 1'b0, 1'b0);
    ticks(40);
    #2;
    checkOutput("pre_reset_frame10", int'(rom_frame), 10);
    step();
    reset = 1'b1;
    #2;
    checkOutput("rst_busy_p1", int'(busy_p1), 0);
    checkOutput("rst_rom_frame", int'(rom_frame), 0);
    checkOutput("rst_blood_on", int'(blood_on), 0);
    step();
    reset = 1'b0;
    ticks(8);
    #2;
    checkOutput("post_reset_idle", int'(busy_p1), 0);

    // Overlap: P2 frame 7, P1 frame 3.
    p1_x = 10'd100; p1_y = 10'd100; p2_x = 10'd130; p2_y = 10'd120;
    applyStimulus(1'b0, 1'b1, 1'b0);
    ticks(16);
    applyStimulus(1'b1, 1'b0, 1'b0);
    ticks(12);
    pixel_x = 10'd140; pixel_y = 10'd130;
    #2;
    checkOutput("ovl_frame_p1", int'(rom_frame), 3);
    checkOutput("ovl_row_p1", int'(rom_row), 30);
    checkOutput("ovl_col_p1", int'(rom_col), 40);
    pixel_x = 10'd180; pixel_y = 10'd170;
    #2;
    checkOutput("ovl_frame_p2", int'(rom_frame), 7);
    checkOutput("ovl_col_p2", int'(rom_col), 50);

    // Retrigger P2 at frame 20 with a coincident vsync tick.
    ticks(52);
    #2;
    checkOutput("retrig_pre_frame20", int'(rom_frame), 20);
    applyStimulus(1'b0, 1'b1, 1'b1);
    #2;
    checkOutput("retrig_frame0", int'(rom_frame), 0);
    checkOutput("retrig_busy_p2", int'(busy_p2), 1);
    ticks(3);
    #2;
    checkOutput("retrig_div_frame0", int'(rom_frame), 0);
    ticks(1);
    #2;
    checkOutput("retrig_div_frame1", int'(rom_frame), 1);

    // Right-edge clipping.
    p1_x = 10'd1000; p1_y = 10'd50; pixel_x = 10'd1023; pixel_y = 10'd60;
    applyStimulus(1'b1, 1'b0, 1'b0);
    #2;
    checkOutput("clip_col23", int'(rom_col), 23);
    checkOutput("clip_row10", int'(rom_row), 10);
    rom_override_en = 1'b1; rom_override_val = 12'hABC;
    step(); #2;
    checkOutput("clip_in_on", int'(blood_on), 1);
    pixel_x = 10'd5;
    #2;
    checkOutput("clip_out_col", int'(rom_col), 0);
    step(); #2;
    checkOutput("clip_out_on", int'(blood_on), 0);
    rom_override_en = 1'b0;

    // Randomized traffic checked by the per-cycle model compare.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 31) == 0) begin
        p1_x = 10'($urandom_range(0, 1023));
        p1_y = 10'($urandom_range(0, 1023));
        if ($urandom_range(0, 1) == 1) begin
          p2_x = 10'(int'(p1_x) + $urandom_range(0, 60));
          p2_y = 10'(int'(p1_y) + $urandom_range(0, 60));
        end else begin
          p2_x = 10'($urandom_range(0, 1023));
          p2_y = 10'($urandom_range(0, 1023));
        end
      end
      j  = $urandom_range(0, 1);
      ox = (j == 0) ? int'(p1_x) : int'(p2_x);
      oy = (j == 0) ? int'(p1_y) : int'(p2_y);
      pixel_x = 10'(ox + $urandom_range(0, 79) - 8);
      pixel_y = 10'(oy + $urandom_range(0, 79) - 8);
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 63) == 0,
                      $urandom_range(0, 7) == 0);
      end
    end

    step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blood_anim_ctrl.md
Name: blood_anim_ctrl

Overview:
Sequences the blood-splatter sprite animation for both fighters and shares the single blood frame ROM bank (64x64, 12-bit RGB per frame, 1-cycle registered-address latency) between them. On a hit pulse it plays frames 0..NUM_FRAMES-1 at a vsync-divided rate anchored at the hit fighter's sprite origin. It generates ROM frame/row/col per scanned pixel, arbitrates overlapping windows, and returns a masked pixel to the display mixer.

Parameters:
NUM_FRAMES, 29, frames in ROM bank (indices 0..28)
FRAME_DIV, 4, vsync ticks per animation frame (>=1)
TRANSP, 12'h000, ROM colour treated as transparent

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
vsync_tick  in  1  one-cycle pulse per video frame
hit_p1  in  1  one-cycle pulse: start/restart P1 splatter
hit_p2  in  1  one-cycle pulse: start/restart P2 splatter
p1_x, p1_y  in  10 each  P1 sprite top-left origin
p2_x, p2_y  in  10 each  P2 sprite top-left origin
pixel_x, pixel_y  in  10 each  current scan pixel
rom_frame  out  5  frame select to ROM bank
rom_row, rom_col  out  6 each  address to ROM bank
rom_data  in  12  ROM colour, valid 1 cycle after address
blood_on  out  1  blood pixel visible (1 cycle after pixel)
blood_rgb  out  12  blood colour, 0 when blood_on=0
busy_p1, busy_p2  out  1 each  animation active

Behaviour:
- Per-player FSM, states IDLE, PLAY. Per player: frame counter (5b), div counter (0..FRAME_DIV-1).
- IDLE: hit -> PLAY, frame=0, div=0. busy=1 in PLAY only.
- PLAY: on vsync_tick, div increments; at div==FRAME_DIV-1 div->0 and frame increments; if frame==NUM_FRAMES-1 at that point -> IDLE, frame=0.
- hit during PLAY: restart at frame 0, div 0. hit and vsync_tick same cycle: hit wins, tick ignored for that player.
- Frame/div change only on vsync_tick or hit, so frame is stable across a scanned video frame.
- Window: player Pn in-window when PLAY and pn_x <= pixel_x <= pn_x+63 and pn_y <= pixel_y <= pn_y+63; compare in 11 bits, no wrap past 1023 (window clipped).
- Arbitration: both in-window -> P1 owns ROM (fixed priority); P2 not shown on that pixel even if P1 colour is transparent.
- Address (combinational from current pixel/state): owner's frame, rom_row=(pixel_y-py)[5:0], rom_col=(pixel_x-px)[5:0]; no owner -> frame/row/col = 0.
- Pipeline: hit_q <= (owner exists), registered. blood_on = hit_q && rom_data!=TRANSP; blood_rgb = blood_on ? rom_data : 0. Latency: pixel at cycle N -> output at cycle N+1.
- Reset (async, any state): both FSMs IDLE, frames/div 0, hit_q 0; busy_p1=busy_p2=0, blood_on=0, blood_rgb=0, rom_frame/row/col=0. Reset mid-animation aborts immediately; no output until next hit after reset release.
- Origin changes during PLAY take effect on the next pixel (sprite follows fighter).

Test Plan:
- Reset: assert reset mid-PLAY at frame 10 -> busy_p1=0, blood_on=0, rom_frame=0 same cycle; after release no animation without hit.
- Full play: hit_p1, FRAME_DIV=4, 116 vsync_ticks -> frame steps 0..28 every 4 ticks; busy_p1 falls on tick 116.
- Addressing/latency: P1 PLAY frame 5, p1=(100,50), pixel=(110,60) -> rom_frame=5, row=10, col=10; rom_data=12'hD00 next cycle -> blood_on=1, blood_rgb=12'hD00; rom_data=0 -> blood_on=0.
- Overlap: both PLAY (P1 frame 3, P2 frame 7), overlapping windows, pixel in both -> rom_frame=3, P1 offsets; pixel only in P2 -> rom_frame=7.
- Retrigger/collision: hit_p2 at frame 20 same cycle as vsync_tick -> frame=0, div=0, busy_p2 stays 1.
- Edge clip: p1_x=1000, pixel_x=1023 -> col=23, in-window; pixel_x=5 -> not in-window, hit_q=0.
